// File: rtl/regfile_arbiter_if.sv
// Requester-side bundle for regfile_arbiter: per-requester request/command
// signals plus the grant, busy and shared read-return signals.
interface regfile_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              req0,   req1;
  logic              lock0,  lock1;
  logic              we0,    we1;
  logic [ADDR_W-1:0] addr0,  addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0,   gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy
  );

  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, busy
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for the shared
// 16x8 register file, with bounded locked bursts and registered read return.
module regfile_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  regfile_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0] R_Addr,
  output logic [ADDR_W-1:0] W_Addr,
  output logic              R_en,
  output logic              W_en,
  output logic [DATA_W-1:0] W_Data,
  input  logic [DATA_W-1:0] R_Data
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              rr, rr_nxt;          // 1 = requester 1 wins the next tie
  logic [HW-1:0]     hold_cnt, hold_nxt;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid0_q, rvalid1_q;

  logic              own_req, own_lock, own_we, oth_req;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              issue, rd_issue, wr_issue, release_own;

  // Owner's command mux and register-file port drive
  always_comb begin
    own_req   = 1'b0;
    own_lock  = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    oth_req   = 1'b0;
    unique case (state)
      OWN0: begin
        own_req   = bus.req0;
        own_lock  = bus.lock0;
        own_we    = bus.we0;
        own_addr  = bus.addr0;
        own_wdata = bus.wdata0;
        oth_req   = bus.req1;
      end
      OWN1: begin
        own_req   = bus.req1;
        own_lock  = bus.lock1;
        own_we    = bus.we1;
        own_addr  = bus.addr1;
        own_wdata = bus.wdata1;
        oth_req   = bus.req0;
      end
      default: ;
    endcase

    issue    = Rst && own_req;
    wr_issue = issue && own_we;
    rd_issue = issue && !own_we;

    W_en   = wr_issue;
    R_en   = rd_issue;
    W_Addr = wr_issue ? own_addr  : '0;
    R_Addr = rd_issue ? own_addr  : '0;
    W_Data = wr_issue ? own_wdata : '0;
  end

  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr;
    hold_nxt    = hold_cnt;
    release_own = !own_req
               || (issue && !own_lock)
               || (issue && (hold_cnt == HOLD_LAST) && oth_req);
    unique case (state)
      IDLE: begin
        hold_nxt = '0;
        if (bus.req0 && bus.req1) state_nxt = rr ? OWN1 : OWN0;
        else if (bus.req0)        state_nxt = OWN0;
        else if (bus.req1)        state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (release_own) begin
          rr_nxt   = (state == OWN0);
          hold_nxt = '0;
          if (oth_req)                   state_nxt = (state == OWN0) ? OWN1 : OWN0;
          else if (own_req && !own_lock) state_nxt = state;
          else                           state_nxt = IDLE;
        end else if (issue) begin
          // Without a competitor the counter just wraps and ownership persists
          hold_nxt = (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + HW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= IDLE;
      rr        <= 1'b0;
      hold_cnt  <= '0;
      rdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr        <= rr_nxt;
      hold_cnt  <= hold_nxt;
      rvalid0_q <= rd_issue && (state == OWN0);
      rvalid1_q <= rd_issue && (state == OWN1);
      if (rd_issue) rdata_q <= R_Data;
    end
  end

  assign bus.gnt0    = (state == OWN0);
  assign bus.gnt1    = (state == OWN1);
  assign bus.busy    = (state != IDLE);
  assign bus.rdata   = rdata_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed self-checking bench for regfile_arbiter with a behavioural
// 16x8 register file attached to its file-side ports.
module tb_regfile_arbiter;

  logic       Clk;
  logic       Rst;
  logic [3:0] R_Addr, W_Addr;
  logic       R_en, W_en;
  logic [7:0] W_Data, R_Data;

  logic       pre_we;
  logic [3:0] pre_addr;
  logic [7:0] pre_data;
  logic [7:0] mem [16] = '{default: 8'h00};

  int checks   = 0;
  int failures = 0;

  regfile_arbiter_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  regfile_arbiter #(.DATA_W(8), .ADDR_W(4), .MAX_HOLD(16)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .bus    (bus),
    .R_Addr (R_Addr),
    .W_Addr (W_Addr),
    .R_en   (R_en),
    .W_en   (W_en),
    .W_Data (W_Data),
    .R_Data (R_Data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (W_en)        mem[W_Addr]   <= W_Data;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end
  assign R_Data = mem[R_Addr];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.lock0 = 0; bus.lock1 = 0;
    bus.we0 = 0;  bus.we1 = 0;  bus.addr0 = 0; bus.addr1 = 0;
    bus.wdata0 = 0; bus.wdata1 = 0;
  endtask

  task automatic do_reset(input logic pre, input logic [3:0] a, input logic [7:0] d);
    clear_inputs();
    Rst = 0;
    pre_we = pre; pre_addr = a; pre_data = d;
    tick();
    pre_we = 0;
    tick();
    Rst = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    Rst = 0;
    pre_we = 0; pre_addr = 0; pre_data = 0;
    tick();
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 4'h7; bus.wdata0 = 8'hFF;
    bus.req1 = 1;
    tick();
    @(negedge Clk);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b000) begin
      failures++; $display("FAIL reset_gnt_busy: got %b want 000", {bus.gnt0, bus.gnt1, bus.busy});
    end
    checks++;
    if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin
      failures++; $display("FAIL reset_rvalid: got %b want 00", {bus.rvalid0, bus.rvalid1});
    end
    checks++;
    if (bus.rdata !== 8'h00) begin
      failures++; $display("FAIL reset_rdata: got %h want 00", bus.rdata);
    end
    checks++;
    if ({R_en, W_en, W_Data} !== 10'd0) begin
      failures++; $display("FAIL reset_enables: got R_en=%b W_en=%b W_Data=%h want 0 0 00", R_en, W_en, W_Data);
    end
    clear_inputs();
  endtask

  task automatic test_single_read();
    do_reset(1'b1, 4'd3, 8'h5A);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'd3; bus.lock0 = 0;
    @(negedge Clk);
    checks++;
    if ({bus.gnt0, bus.busy, R_en} !== 3'b000) begin
      failures++; $display("FAIL read_idle: got gnt0/busy/R_en=%b want 000", {bus.gnt0, bus.busy, R_en});
    end
    tick();
    @(negedge Clk);
    checks++;
    if ({bus.gnt0, R_en, W_en} !== 3'b110) begin
      failures++; $display("FAIL read_issue: got gnt0/R_en/W_en=%b want 110", {bus.gnt0, R_en, W_en});
    end
    checks++;
    if (R_Addr !== 4'd3) begin
      failures++; $display("FAIL read_addr: got %0d want 3", R_Addr);
    end
    tick();
    bus.req0 = 0;
    @(negedge Clk);
    checks++;
    if ({bus.rvalid0, bus.rvalid1, R_en} !== 3'b100) begin
      failures++; $display("FAIL read_rvalid: got rvalid0/rvalid1/R_en=%b want 100", {bus.rvalid0, bus.rvalid1, R_en});
    end
    checks++;
    if (bus.rdata !== 8'h5A) begin
      failures++; $display("FAIL read_rdata: got %h want 5a", bus.rdata);
    end
    tick();
    @(negedge Clk);
    checks++;
    if ({bus.busy, bus.gnt0, bus.rvalid0} !== 3'b000) begin
      failures++; $display("FAIL read_release: got busy/gnt0/rvalid0=%b want 000", {bus.busy, bus.gnt0, bus.rvalid0});
    end
    checks++;
    if (bus.rdata !== 8'h5A) begin
      failures++; $display("FAIL read_rdata_hold: got %h want 5a", bus.rdata);
    end
  endtask

  task automatic test_contention();
    do_reset(1'b0, 4'd0, 8'h00);
    bus.req0 = 1; bus.req1 = 1; bus.addr0 = 4'd1; bus.addr1 = 4'd2;
    tick();
    @(negedge Clk);
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10 || R_Addr !== 4'd1) begin
      failures++; $display("FAIL contend_first: got gnt=%b R_Addr=%0d want 10 1", {bus.gnt0, bus.gnt1}, R_Addr);
    end
    tick();
    bus.req0 = 0;
    @(negedge Clk);
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01 || R_Addr !== 4'd2) begin
      failures++; $display("FAIL contend_second: got gnt=%b R_Addr=%0d want 01 2", {bus.gnt0, bus.gnt1}, R_Addr);
    end
    checks++;
    if (bus.rvalid0 !== 1'b1) begin
      failures++; $display("FAIL contend_rvalid0: got %b want 1", bus.rvalid0);
    end
    tick();
    bus.req1 = 0;
    @(negedge Clk);
    checks++;
    if ({bus.rvalid0, bus.rvalid1} !== 2'b01) begin
      failures++; $display("FAIL contend_rvalid1: got %b want 01", {bus.rvalid0, bus.rvalid1});
    end
    tick();
    @(negedge Clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL contend_idle: got busy=%b want 0", bus.busy);
    end
    bus.req0 = 1; bus.req1 = 1;
    tick();
    @(negedge Clk);
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      failures++; $display("FAIL contend_rr_back: got gnt=%b want 10", {bus.gnt0, bus.gnt1});
    end
    clear_inputs();
  endtask

  task automatic test_locked_burst();
    logic [7:0] exp_d;
    do_reset(1'b0, 4'd0, 8'h00);
    bus.req0 = 1; bus.lock0 = 1; bus.we0 = 1; bus.addr0 = 4'd0; bus.wdata0 = 8'h10;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4'd0;
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_d = 8'h10 + 8'(i);
      bus.addr0 = 4'(i); bus.wdata0 = exp_d; bus.lock0 = (i < 3);
      @(negedge Clk);
      checks++;
      if ({bus.gnt0, W_en, R_en} !== 3'b110 || W_Addr !== 4'(i) || W_Data !== exp_d) begin
        failures++;
        $display("FAIL burst_write%0d: got gnt0/W_en/R_en=%b W_Addr=%0d W_Data=%h want 110 %0d %h",
                 i, {bus.gnt0, W_en, R_en}, W_Addr, W_Data, i, exp_d);
      end
      tick();
    end
    bus.req0 = 0;
    @(negedge Clk);
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      failures++; $display("FAIL burst_handover: got gnt=%b want 01", {bus.gnt0, bus.gnt1});
    end
    for (int i = 0; i < 4; i++) begin
      exp_d = 8'h10 + 8'(i);
      checks++;
      if (mem[i] !== exp_d) begin
        failures++; $display("FAIL burst_file%0d: got %h want %h", i, mem[i], exp_d);
      end
    end
    clear_inputs();
  endtask

  task automatic test_hold_limit();
    int pulses;
    int gnt1_at;
    do_reset(1'b0, 4'd0, 8'h00);
    pulses = 0; gnt1_at = -1;
    bus.req0 = 1; bus.lock0 = 1; bus.we0 = 1;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 4'hF; bus.wdata1 = 8'hEE;
    tick();
    for (int cyc = 1; cyc <= 24; cyc++) begin
      bus.addr0 = 4'(cyc); bus.wdata0 = 8'(cyc);
      @(negedge Clk);
      if (bus.gnt1) begin
        gnt1_at = cyc;
        break;
      end
      if (bus.gnt0 && W_en) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 16) begin
      failures++; $display("FAIL hold_pulses: got %0d want 16", pulses);
    end
    checks++;
    if (gnt1_at !== 17) begin
      failures++; $display("FAIL hold_handover_cycle: got %0d want 17", gnt1_at);
    end
    clear_inputs();

    do_reset(1'b0, 4'd0, 8'h00);
    pulses = 0;
    bus.req0 = 1; bus.lock0 = 1; bus.we0 = 1;
    tick();
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge Clk);
      if (bus.gnt0 && W_en) pulses++;
      tick();
    end
    @(negedge Clk);
    checks++;
    if (pulses !== 20 || bus.gnt0 !== 1'b1) begin
      failures++; $display("FAIL hold_wrap: got pulses=%0d gnt0=%b want 20 1", pulses, bus.gnt0);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1, 4'd9, 8'hC3);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'd9; bus.lock0 = 1;
    tick();
    @(negedge Clk);
    checks++;
    if (R_en !== 1'b1) begin
      failures++; $display("FAIL mid_first_read: got R_en=%b want 1", R_en);
    end
    tick();
    Rst = 0;
    @(negedge Clk);
    checks++;
    if ({bus.rvalid0, bus.rdata} !== {1'b1, 8'hC3}) begin
      failures++; $display("FAIL mid_pre_rdata: got rvalid0=%b rdata=%h want 1 c3", bus.rvalid0, bus.rdata);
    end
    checks++;
    if ({R_en, W_en} !== 2'b00) begin
      failures++; $display("FAIL mid_suppress: got R_en/W_en=%b want 00", {R_en, W_en});
    end
    tick();
    Rst = 1;
    @(negedge Clk);
    checks++;
    if ({bus.gnt0, bus.rvalid0, bus.busy} !== 3'b000 || bus.rdata !== 8'h00) begin
      failures++; $display("FAIL mid_after: got gnt0/rvalid0/busy=%b rdata=%h want 000 00",
                           {bus.gnt0, bus.rvalid0, bus.busy}, bus.rdata);
    end
    clear_inputs();
  endtask

  task automatic test_coherence();
    logic rv0_seen;
    do_reset(1'b0, 4'd0, 8'h00);
    rv0_seen = 0;
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 4'd5; bus.wdata0 = 8'hA7;
    @(negedge Clk); rv0_seen |= bus.rvalid0;
    tick();
    @(negedge Clk); rv0_seen |= bus.rvalid0;
    checks++;
    if ({W_en, W_Addr, W_Data} !== {1'b1, 4'd5, 8'hA7}) begin
      failures++; $display("FAIL coh_write: got W_en=%b W_Addr=%0d W_Data=%h want 1 5 a7", W_en, W_Addr, W_Data);
    end
    tick();
    bus.req0 = 0; bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4'd5;
    @(negedge Clk); rv0_seen |= bus.rvalid0;
    tick();
    @(negedge Clk); rv0_seen |= bus.rvalid0;
    checks++;
    if ({bus.gnt1, R_en, R_Addr} !== {1'b1, 1'b1, 4'd5}) begin
      failures++; $display("FAIL coh_read: got gnt1=%b R_en=%b R_Addr=%0d want 1 1 5", bus.gnt1, R_en, R_Addr);
    end
    tick();
    bus.req1 = 0;
    @(negedge Clk); rv0_seen |= bus.rvalid0;
    checks++;
    if ({bus.rvalid1, bus.rdata} !== {1'b1, 8'hA7}) begin
      failures++; $display("FAIL coh_rdata: got rvalid1=%b rdata=%h want 1 a7", bus.rvalid1, bus.rdata);
    end
    tick();
    @(negedge Clk); rv0_seen |= bus.rvalid0;
    checks++;
    if (bus.rvalid1 !== 1'b0) begin
      failures++; $display("FAIL coh_pulse: got rvalid1=%b want 0", bus.rvalid1);
    end
    checks++;
    if (rv0_seen !== 1'b0) begin
      failures++; $display("FAIL coh_rvalid0: got %b want 0", rv0_seen);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_locked_burst();
    test_hold_limit();
    test_reset_mid();
    test_coherence();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Two-requester arbiter and access sequencer for the shared 16x8 register file (Register16_8).
- Lets two datapath controllers, for example two statistics engines, each read and write the register file without colliding.
- Round-robin grant, optional locked bursts with a bounded hold time, registered read-data return.
- Sits between the requesting FSMs and the register file ports R_Addr, W_Addr, R_en, W_en, W_Data and R_Data.

Parameters:
- DATA_W, 8, register file data width.
- ADDR_W, 4, register file address width (16 entries).
- MAX_HOLD, 16, maximum consecutive accesses a locked owner may issue while the other requester is waiting.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Rst  input  1  reset, synchronous, active-low.
- req0/req1  input  1  access request; held high while the requester wants the file.
- lock0/lock1  input  1  keep ownership after an access (burst / read-modify-write).
- we0/we1  input  1  1 = write, 0 = read, for the current access.
- addr0/addr1  input  ADDR_W  access address.
- wdata0/wdata1  input  DATA_W  write data.
- gnt0/gnt1  output  1  registered ownership flag; never both 1.
- rvalid0/rvalid1  output  1  one-cycle pulse, read data for that requester is valid on rdata.
- rdata  output  DATA_W  registered read data, shared by both requesters.
- busy  output  1  state is not IDLE.
- R_Addr  output  ADDR_W  to register file.
- W_Addr  output  ADDR_W  to register file.
- R_en  output  1  to register file.
- W_en  output  1  to register file.
- W_Data  output  DATA_W  to register file.
- R_Data  input  DATA_W  from register file; combinational read.

Behaviour:
- States and outputs:
  - States: IDLE, OWN0, OWN1. gnt0 = (state==OWN0), gnt1 = (state==OWN1). busy = !IDLE.
  - Reset (Rst=0 at posedge): state IDLE, rr pointer favours requester 0, hold_cnt=0, rdata=0, rvalid0/1=0, gnt0/1=0.
  - R_en, W_en and W_Data are forced to 0 in any cycle where Rst=0.
- IDLE arbitration:
  - Only req0 high: next state OWN0. Only req1 high: OWN1.
  - Both high: the requester favoured by the rr pointer wins.
  - Grant latency: 1 cycle from req sampled in IDLE to gnt high.
- Issue:
  - An access issues in any cycle where gntX=1 and reqX=1.
  - Write issue: W_en=1, W_Addr=addrX, W_Data=wdataX.
  - Read issue: R_en=1, R_Addr=addrX.
  - All of these are combinational from the owner's inputs. R_en and W_en are never both 1. With no issue, both enables are 0 and the address outputs are 0.
- Read return:
  - On the posedge ending a read issue, rdata <= R_Data and rvalidX <= 1 for exactly one cycle.
  - rdata holds its value until the next read completes.
  - Write issues produce no rvalid.
- Release evaluation (at each posedge in OWNX):
  - Release if reqX=0, or if (issue and lockX=0), or if (issue and hold_cnt==MAX_HOLD-1 and the other req is high).
  - Otherwise stay, and hold_cnt increments on each issue.
  - hold_cnt only saturates ownership while the other side is requesting. With no competitor, hold_cnt wraps to 0 at MAX_HOLD-1 and the owner keeps the grant.
- Release target:
  - Other req high: go straight to OWNother. There is no idle bubble.
  - Else own req still high with lock=0: stay in OWNX (re-grant, hold_cnt=0).
  - Else: IDLE.
- Pointer and counter on release:
  - Every release sets the rr pointer to favour the other requester.
  - hold_cnt clears on every state change.
- Reset mid-operation: any in-flight read is dropped (no rvalid), the issue in the reset cycle is suppressed, and state returns to IDLE.
- Width rules: hold_cnt is $clog2(MAX_HOLD) bits, minimum 1. Addresses wrap naturally within ADDR_W; there is no range check.

Test Plan:
1. Single read: file[3]=0x5A, req0=1, we0=0, addr0=3, lock0=0 from IDLE -> gnt0=1 cycle 1 with R_en=1, R_Addr=3; cycle 2 rvalid0=1, rdata=0x5A; with req0 dropped, state IDLE and busy=0.
2. Contention after reset: req0=req1=1, both unlocked -> gnt0 on cycle 1, gnt1 on cycle 2 with no bubble. A later simultaneous pair -> gnt0 first again, because the pointer favours 0 after serving 1.
3. Locked burst: lock0=1 writes addr 0..3 with data 0x10..0x13 while req1=1 -> gnt0 held 4 issue cycles, W_en=1 each; lock0 drops on the 4th -> gnt1 the next cycle; file[0..3]=0x10..0x13.
4. Hold limit: MAX_HOLD=16, lock0 kept high for 20 writes, req1 pending -> exactly 16 W_en pulses under gnt0, then gnt1=1 on the following cycle.
5. Reset mid-operation: Rst=0 in a cycle where OWN0 is issuing a read -> R_en=0 that cycle, next cycle gnt0=0, rvalid0=0, busy=0, rdata=0.
6. Cross-requester coherence: req0 writes addr 5 = 0xA7, then req1 reads addr 5 -> rvalid1=1, rdata=0xA7; rvalid0 stays 0 throughout.
